imem_loader: RTL and testbench

Hardware program loader for the RV32I pipeline's instruction memory. It replaces file-based preloading of program words with a byte stream accepted over a valid/ready handshake. The block assembles little-endian 32-bit words and writes them sequentially into instruction memory. It holds the core in reset until a length-framed, checksummed image has loaded, then releases the core by driving its reset and enable.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_word_packer.sv | 60 ++++++
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_e        : loader FSM states
//   BYTES_PER_WORD : stream bytes per 32-bit instruction word
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream and keeps a running XOR.
// Ports:
//   clk, rst    : clock, synchronous active-low reset
//   clear       : restart (clears byte index, partial word and checksum)
//   accept      : byte is consumed this cycle (folded into the checksum)
//   pack        : accepted byte is a data byte (advances the byte index)
//   data        : stream byte
//   word        : assembled word, meaningful while word_valid=1
//   word_valid  : the 4th byte of a word is being accepted this cycle
//   csum        : XOR of all accepted bytes since the last clear
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic        pack,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [7:0]  csum
);

    localparam logic [1:0] LastIdx = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  idx_q;
    logic [23:0] low_q;
    logic [7:0]  csum_q;
    logic        take;

    assign take = accept && pack;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            idx_q  <= '0;
            low_q  <= '0;
            csum_q <= '0;
        end else begin
            if (accept) begin
                csum_q <= csum_q ^ data;
            end
            if (take) begin
                idx_q <= idx_q + 2'd1;
                unique case (idx_q)
                    2'd0:    low_q[7:0]   <= data;
                    2'd1:    low_q[15:8]  <= data;
                    2'd2:    low_q[23:16] <= data;
                    default: ;  // top byte goes straight out on word
                endcase
            end
        end
    end

    // Word is presented in the same cycle as its last byte; the top registers it.
    assign word       = {data, low_q};
    assign word_valid = take && (idx_q == LastIdx);
    assign csum       = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-framed, XOR-checksummed program image from a byte stream into
// instruction memory, holding the core in reset until the image is verified.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   start             : pulse, begin/restart a load
//   in_valid/in_ready/in_data : byte-stream handshake
//   imem_we/imem_addr/imem_wdata : instruction-memory write port
//   core_rst, core_enable : core control (released only after a good load)
//   busy, done, error : load status
//   words_loaded      : words written in the current/last load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              core_enable,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam logic [16:0] DepthW = 17'(DEPTH);

    state_e              state_q, state_d;
    logic [15:0]         len_q;
    logic [ADDR_W-1:0]   word_idx_q;
    logic [15:0]         words_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic                busy_st;
    logic                fire;
    logic [15:0]         len_full;
    logic                last_word;
    logic [31:0]         word;
    logic                word_valid;
    logic [7:0]          csum;

    assign busy_st  = (state_q == StLenLo) || (state_q == StLenHi) ||
                      (state_q == StData)  || (state_q == StCheck);
    // A start pulse blocks the stream so a concurrent byte is never consumed.
    assign in_ready = busy_st && !start;
    assign fire     = in_valid && in_ready;
    assign len_full = {in_data, len_q[7:0]};
    assign last_word = (words_q + 16'd1) == len_q;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .accept     (fire && (state_q != StCheck)),
        .pack       (state_q == StData),
        .data       (in_data),
        .word       (word),
        .word_valid (word_valid),
        .csum       (csum)
    );

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StLenLo;
        end else begin
            unique case (state_q)
                StIdle: ;
                StLenLo: if (fire) state_d = StLenHi;
                StLenHi: begin
                    if (fire) begin
                        if ({1'b0, len_full} > DepthW) state_d = StError;
                        else if (len_full == 16'd0)    state_d = StCheck;
                        else                           state_d = StData;
                    end
                end
                StData: if (word_valid && last_word) state_d = StCheck;
                StCheck: begin
                    if (fire) state_d = (in_data == csum) ? StDone : StError;
                end
                StDone, StError: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_idx_q <= '0;
            words_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            // Write strobe is registered, so a word completed just before a
            // start pulse still reaches memory.
            we_q    <= word_valid;
            if (word_valid) begin
                addr_q  <= word_idx_q;
                wdata_q <= word;
            end
            if (start) begin
                word_idx_q <= '0;
                words_q    <= '0;
            end else if (word_valid) begin
                word_idx_q <= word_idx_q + ADDR_W'(1);
                words_q    <= words_q + 16'd1;
            end
            if (fire && state_q == StLenLo) len_q[7:0]  <= in_data;
            if (fire && state_q == StLenHi) len_q[15:8] <= in_data;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;
    assign busy         = busy_st;
    assign done         = (state_q == StDone);
    assign error        = (state_q == StError);
    assign core_enable  = (state_q == StDone);
    assign core_rst     = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              core_enable;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    imem_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .core_enable  (core_enable),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    time         last_acc = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] wr_lat[$];
    logic [7:0]  fr[$];

    // Record every write with its distance from the last accepted byte edge;
    // a write one cycle after acceptance is seen at the following negedge (5).
    always @(negedge clk) begin
        if (rst && imem_we) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_lat.push_back(32'($time - last_acc));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
        wr_lat.delete();
    endtask

    // Callers sit at posedge+1; returns at posedge+1.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                last_acc = $time;
                ok = 1'b1;
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input int gap);
        foreach (bytes[i]) send_byte(bytes[i], gap);
    endtask

    // Two-word program; the correct checksum is 02^00^13^00^10^00^7F^00^00^00 = 7E.
    task automatic nominal(input int gap, input logic [7:0] ck, input logic good);
        clear_writes();
        pulse_start();
        fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, ck};
        send_frame(fr, gap);
        repeat (2) @(posedge clk);
        #1;
        check("nom_nwrites", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("nom_addr0", wr_addr[0], 32'd0);
            check("nom_data0", wr_data[0], 32'h0010_0013);
            check("nom_lat0",  wr_lat[0],  32'd5);
            check("nom_addr1", wr_addr[1], 32'd1);
            check("nom_data1", wr_data[1], 32'h0000_007F);
            check("nom_lat1",  wr_lat[1],  32'd5);
        end
        check("nom_done",     32'(done),        32'(good));
        check("nom_error",    32'(error),       32'(!good));
        check("nom_core_rst", 32'(core_rst),    32'(!good));
        check("nom_core_en",  32'(core_enable), 32'(good));
        check("nom_words",    32'(words_loaded), 32'd2);
        check("nom_busy",     32'(busy),        32'd0);
        check("nom_ready",    32'(in_ready),    32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_done",     32'(done),        32'd0);
        check("rst_error",    32'(error),       32'd0);
        check("rst_core_rst", 32'(core_rst),    32'd1);
        check("rst_core_en",  32'(core_enable), 32'd0);
        check("rst_we",       32'(imem_we),     32'd0);
        check("rst_addr",     32'(imem_addr),   32'd0);
        check("rst_wdata",    imem_wdata,       32'd0);
        check("rst_words",    32'(words_loaded), 32'd0);
        check("rst_ready",    32'(in_ready),    32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Nominal, bad checksum, then back-pressured nominal.
        nominal(0, 8'h7E, 1'b1);
        nominal(0, 8'h7F, 1'b0);
        nominal(3, 8'h7E, 1'b1);

        // Empty image: good then bad checksum.
        clear_writes();
        pulse_start();
        check("restart_clr_done", 32'(done), 32'd0);
        check("restart_busy",     32'(busy), 32'd1);
        fr = '{8'h00, 8'h00, 8'h00};
        send_frame(fr, 0);
        @(posedge clk);
        #1;
        check("empty_nwrites", 32'(wr_addr.size()), 32'd0);
        check("empty_done",    32'(done),        32'd1);
        check("empty_core_en", 32'(core_enable), 32'd1);
        check("empty_words",   32'(words_loaded), 32'd0);
        pulse_start();
        fr = '{8'h00, 8'h00, 8'h01};
        send_frame(fr, 0);
        #1;
        check("empty_bad_error",    32'(error),    32'd1);
        check("empty_bad_done",     32'(done),     32'd0);
        check("empty_bad_core_rst", 32'(core_rst), 32'd1);

        // Oversize length 0x0101 = 257 > DEPTH.
        clear_writes();
        pulse_start();
        fr = '{8'h01, 8'h01};
        send_frame(fr, 0);
        check("over_error", 32'(error),    32'd1);
        check("over_ready", 32'(in_ready), 32'd0);
        check("over_busy",  32'(busy),     32'd0);
        in_valid = 1'b1;
        in_data  = 8'h13;
        repeat (3) @(posedge clk);
        #1;
        check("over_ready_hold", 32'(in_ready), 32'd0);
        check("over_error_hold", 32'(error),    32'd1);
        in_valid = 1'b0;
        check("over_nwrites", 32'(wr_addr.size()), 32'd0);

        // Restart after 6 data bytes, with a byte offered in the start cycle.
        pulse_start();
        fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h7F, 8'h00};
        send_frame(fr, 0);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        check("rs_ready_in_start", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("rs_busy",  32'(busy),         32'd1);
        check("rs_words", 32'(words_loaded), 32'd0);
        clear_writes();
        // 01^00^AA^BB^CC^DD = 01
        fr = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        send_frame(fr, 0);
        @(posedge clk);
        #1;
        check("rs_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("rs_addr", wr_addr[0], 32'd0);
            check("rs_data", wr_data[0], 32'hDDCC_BBAA);
        end
        check("rs_done",  32'(done),         32'd1);
        check("rs_words", 32'(words_loaded), 32'd1);

        // Reset in the middle of DATA.
        pulse_start();
        fr = '{8'h01, 8'h00, 8'h11, 8'h22};
        send_frame(fr, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("mrst_busy",     32'(busy),        32'd0);
        check("mrst_done",     32'(done),        32'd0);
        check("mrst_error",    32'(error),       32'd0);
        check("mrst_core_rst", 32'(core_rst),    32'd1);
        check("mrst_core_en",  32'(core_enable), 32'd0);
        check("mrst_addr",     32'(imem_addr),   32'd0);
        check("mrst_wdata",    imem_wdata,       32'd0);
        check("mrst_words",    32'(words_loaded), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready", 32'(in_ready), 32'd0);
        check("idle_busy",  32'(busy),     32'd0);
        in_valid = 1'b0;
        clear_writes();
        pulse_start();
        fr = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        send_frame(fr, 0);
        @(posedge clk);
        #1;
        check("post_rst_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("post_rst_data", wr_data[0], 32'hDDCC_BBAA);
        end
        check("post_rst_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
